alu_sequencer: RTL and testbench

Button-driven controller that sequences the shared ALU datapath. It captures operand A, operand B and the 6-bit operation code from the 8-bit `entrada` bus on rising edges of the three `pulsador` buttons. It then issues the operation to the combinational ALU and registers the result with a valid flag. It sits between the board I/O and the ALU and replaces ad-hoc per-button latching in the top level.

---
 rtl/alu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer -- button-driven operand/opcode sequencer for the shared ALU.
//
// Captures operand A, operand B and the opcode from the switch bus `entrada`
// on rising edges of the three buttons. It then issues the operation to the
// external combinational ALU for one cycle and registers its result with a
// valid flag.
//
// Ports:
//   clk         in            rising-edge clock
//   reset       in            synchronous, active-high
//   pulsador    in  [2:0]     buttons: [0] load A, [1] load B, [2] load op / execute
//   entrada     in  [NBITS]   switch data bus
//   alu_result  in  [NBITS]   combinational ALU result
//   alu_a       out [NBITS]   operand A register
//   alu_b       out [NBITS]   operand B register
//   alu_op      out [COD_OP]  opcode register
//   result      out [NBITS]   registered ALU result
//   valid       out           result matches current A/B/op
//   busy        out           high during the single EXEC cycle
//   error       out           last op load was illegal
//
// Build option: define ALU_SEQ_OPCHECK_EN to reject illegal opcodes.
// An illegal OP edge then only sets `error`. Without it, every code
// executes and `error` stays 0.
//
// state     | meaning
// S_IDLE    | nothing loaded, waiting for A
// S_WAIT_B  | A loaded, waiting for B
// S_WAIT_OP | A and B loaded, waiting for opcode
// S_EXEC    | ALU inputs stable, result captured at end of cycle
// S_DONE    | result valid and held; OP edge chains a new operation

module alu_sequencer #(
   parameter int NBITS  = 8,
   parameter int COD_OP = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        pulsador,
   input  logic [NBITS-1:0]  entrada,
   input  logic [NBITS-1:0]  alu_result,
   output logic [NBITS-1:0]  alu_a,
   output logic [NBITS-1:0]  alu_b,
   output logic [COD_OP-1:0] alu_op,
   output logic [NBITS-1:0]  result,
   output logic              valid,
   output logic              busy,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_B,
      S_WAIT_OP,
      S_EXEC,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          prev_q, prev_d;
   logic [NBITS-1:0]    alu_a_q, alu_a_d;
   logic [NBITS-1:0]    alu_b_q, alu_b_d;
   logic [COD_OP-1:0]   alu_op_q, alu_op_d;
   logic [NBITS-1:0]    result_q, result_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                error_q, error_d;

   logic [2:0]          btn_edge;
   logic                sel_a, sel_b, sel_op;
   logic [COD_OP-1:0]   op_in;
   logic                op_ok;

`ifdef ALU_SEQ_OPCHECK_EN
   function automatic logic op_legal(input logic [COD_OP-1:0] op);
      case (op)
         6'b100000, 6'b100010, 6'b100100, 6'b100101,
         6'b100110, 6'b100111, 6'b000011, 6'b000010: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction
`endif

   always_comb begin
      btn_edge = pulsador & ~prev_q;
      // Only the highest-priority edge acts; lower ones are discarded.
      sel_a    = btn_edge[0];
      sel_b    = btn_edge[1] & ~btn_edge[0];
      sel_op   = btn_edge[2] & ~(|btn_edge[1:0]);
      op_in    = entrada[COD_OP-1:0];
`ifdef ALU_SEQ_OPCHECK_EN
      op_ok    = op_legal(op_in);
`else
      op_ok    = 1'b1;
`endif

      state_d  = state_q;
      prev_d   = pulsador;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      result_d = result_q;
      valid_d  = valid_q;
      error_d  = error_q;

      case (state_q)
         S_IDLE: begin
            if (sel_a) begin
               alu_a_d = entrada;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (sel_a) begin
               alu_a_d = entrada;
            end else if (sel_b) begin
               alu_b_d = entrada;
               state_d = S_WAIT_OP;
            end
         end
         S_WAIT_OP, S_DONE: begin
            if (sel_a) begin
               alu_a_d = entrada;
               valid_d = 1'b0;
               state_d = S_WAIT_B;
            end else if (sel_b) begin
               alu_b_d = entrada;
               valid_d = 1'b0;
               state_d = S_WAIT_OP;
            end else if (sel_op) begin
               if (op_ok) begin
                  alu_op_d = op_in;
                  valid_d  = 1'b0;
                  error_d  = 1'b0;
                  state_d  = S_EXEC;
               end else begin
                  // Rejected op: state, op and any held result stay put.
                  error_d  = 1'b1;
               end
            end
         end
         S_EXEC: begin
            result_d = alu_result;
            valid_d  = 1'b1;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_EXEC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         // All ones: a button held through reset must be released first.
         prev_q   <= '1;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         error_q  <= error_d;
      end
   end

   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign alu_op = alu_op_q;
   assign result = result_q;
   assign valid  = valid_q;
   assign busy   = busy_q;
   assign error  = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] pulsador;
   logic [7:0] entrada;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, result;
   logic [5:0] alu_op;
   logic       valid, busy, error;

   int n_tests = 0;
   int n_fail  = 0;

   alu_sequencer #(.NBITS(8), .COD_OP(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .pulsador   (pulsador),
      .entrada    (entrada),
      .alu_result (alu_result),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .result     (result),
      .valid      (valid),
      .busy       (busy),
      .error      (error)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
      case (op)
         6'b100000: return a + b;
         6'b100010: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b000011: return 8'($signed(a) >>> b);
         6'b000010: return a >> b;
         default:   return 8'h00;
      endcase
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                        6'b100110, 6'b100111, 6'b000011, 6'b000010};
   endfunction

   // External ALU the sequencer drives.
   always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

`ifdef ALU_SEQ_OPCHECK_EN
   localparam bit CHECK_OPS = 1'b1;
`else
   localparam bit CHECK_OPS = 1'b0;
`endif

   // Reference model: tracks which operands are present and whether an
   // operation is in flight, rather than an explicit state machine.
   logic [7:0] m_a, m_b, m_res;
   logic [5:0] m_op;
   logic       m_valid, m_exec, m_err, m_have_a, m_have_b;
   logic [2:0] m_prev;

   always @(posedge clk) begin
      logic [2:0] e;
      if (reset) begin
         m_a = 0; m_b = 0; m_op = 0; m_res = 0;
         m_valid = 0; m_exec = 0; m_err = 0;
         m_have_a = 0; m_have_b = 0; m_prev = 3'b111;
      end else begin
         e = pulsador & ~m_prev;
         m_prev = pulsador;
         if (m_exec) begin
            m_res   = alu_fn(m_a, m_b, m_op);
            m_valid = 1;
            m_exec  = 0;
         end else if (e[0]) begin
            m_a = entrada; m_have_a = 1; m_have_b = 0; m_valid = 0;
         end else if (e[1]) begin
            if (m_have_a) begin
               m_b = entrada; m_have_b = 1; m_valid = 0;
            end
         end else if (e[2]) begin
            if (m_have_a && m_have_b) begin
               if (!CHECK_OPS || is_legal(entrada[5:0])) begin
                  m_op = entrada[5:0]; m_exec = 1; m_valid = 0; m_err = 0;
               end else begin
                  m_err = 1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   bit model_on = 0;
   always @(negedge clk) begin
      if (model_on) begin
         chk("m_alu_a",  alu_a,          m_a);
         chk("m_alu_b",  alu_b,          m_b);
         chk("m_alu_op", {2'b00, alu_op}, {2'b00, m_op});
         chk("m_result", result,         m_res);
         chk("m_valid",  {7'd0, valid},  {7'd0, m_valid});
         chk("m_busy",   {7'd0, busy},   {7'd0, m_exec});
         chk("m_error",  {7'd0, error},  {7'd0, m_err});
      end
   end

   // Pulse one button set for one cycle; returns at the negedge after the edge acted.
   task automatic press(input logic [2:0] b, input logic [7:0] d);
      @(negedge clk);
      entrada  = d;
      pulsador = b;
      @(negedge clk);
      pulsador = 3'b000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   task automatic run_op(input logic [7:0] op, input logic [7:0] exp, input string name);
      press(3'b100, op);
      chk({name, "_busy"},  {7'd0, busy},  8'd1);
      chk({name, "_vlow"},  {7'd0, valid}, 8'd0);
      @(negedge clk);
      chk({name, "_res"},   result,        exp);
      chk({name, "_valid"}, {7'd0, valid}, 8'd1);
      chk({name, "_bdone"}, {7'd0, busy},  8'd0);
   endtask

   initial begin
      reset = 1; pulsador = 3'b000; entrada = 8'h00;
      @(posedge clk);
      model_on = 1;
      repeat (2) @(negedge clk);
      chk("rst_result", result, 8'h00);
      chk("rst_valid",  {7'd0, valid}, 8'd0);
      chk("rst_alu_a",  alu_a, 8'h00);
      reset = 0;

      press(3'b001, 8'h04);
      press(3'b010, 8'h05);
      run_op(8'h20, 8'h09, "add");

      run_op(8'h22, 8'hFF, "sub");
      run_op(8'h24, 8'h04, "and");
      run_op(8'h25, 8'h05, "or");
      run_op(8'h26, 8'h01, "xor");

      press(3'b001, 8'h09);
      press(3'b010, 8'h02);
      run_op(8'h03, 8'h02, "sra");
      run_op(8'h02, 8'h02, "srl");
      run_op(8'h27, 8'hF4, "nor");

      // Simultaneous A+B in IDLE: only A loads.
      do_reset();
      press(3'b011, 8'h07);
      chk("prio_a", alu_a, 8'h07);
      chk("prio_b", alu_b, 8'h00);
      press(3'b010, 8'h33);
      chk("prio_waitb", alu_b, 8'h33);
      run_op(8'h20, 8'h3A, "add2");

      press(3'b100, 8'h3F);
`ifdef ALU_SEQ_OPCHECK_EN
      chk("ill_error", {7'd0, error}, 8'd1);
      chk("ill_op",    {2'b00, alu_op}, 8'h20);
      chk("ill_valid", {7'd0, valid}, 8'd1);
      @(negedge clk);
      chk("ill_res",   result, 8'h3A);
      run_op(8'h20, 8'h3A, "legal");
      chk("clr_error", {7'd0, error}, 8'd0);
`else
      chk("any_op",    {2'b00, alu_op}, 8'h3F);
      chk("any_error", {7'd0, error}, 8'd0);
      @(negedge clk);
      chk("any_res",   result, 8'h00);
`endif

      // Reset during EXEC discards the result.
      press(3'b100, 8'h25);
      chk("exec_busy", {7'd0, busy}, 8'd1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("rexec_res",   result, 8'h00);
      chk("rexec_valid", {7'd0, valid}, 8'd0);
      chk("rexec_busy",  {7'd0, busy}, 8'd0);
      @(negedge clk);
      chk("rexec_res2",  result, 8'h00);

      // Button held through reset is not an edge until released.
      @(negedge clk);
      reset = 1; pulsador = 3'b001; entrada = 8'h55;
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (3) @(negedge clk);
      chk("held_noload", alu_a, 8'h00);
      pulsador = 3'b000;
      press(3'b001, 8'h55);
      chk("held_reload", alu_a, 8'h55);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
